multdiv: RTL and testbench

Iterative signed 32-bit multiply/divide unit for the execute stage. It reuses one `alu` instance as its add/subtract datapath: it drives the ALU operand and opcode inputs every cycle and consumes the ALU `data_result` as its partial-sum/partial-remainder. Results return to the processor through a start/ready handshake. Multiply uses radix-2 Booth; divide uses non-restoring with final sign correction.

---
 rtl/multdiv.sv | 174 +++++++++++++++++
 tb/tb_multdiv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (non-restoring) unit.
// Define MULTDIV_EARLY_DIV0_EN to complete a divide by zero one cycle after start.

module alu #(
    parameter int W = 32
) (
    input  logic [W-1:0] data_operandA,
    input  logic [W-1:0] data_operandB,
    input  logic [4:0]   ctrl_ALUopcode,
    output logic [W-1:0] data_result
);

    always_comb begin
        data_result = data_operandA + data_operandB;
        unique case (ctrl_ALUopcode)
            5'b00000: data_result = data_operandA + data_operandB;
            5'b00001: data_result = data_operandA - data_operandB;
            5'b00010: data_result = data_operandA & data_operandB;
            5'b00011: data_result = data_operandA | data_operandB;
            default:  data_result = data_operandA + data_operandB;
        endcase
    end

endmodule

module multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [32:0] acc;
    logic [31:0] q;
    logic        qm1;
    logic [31:0] opb;
    logic        is_div;
    logic        neg_q;
    logic        div0;
    logic        div_ovf;

    logic [32:0] alu_a;
    logic [32:0] alu_b;
    logic [32:0] alu_y;
    logic [4:0]  alu_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        start;

    assign start = ctrl_MULT | ctrl_DIV;
    assign abs_a = data_operandA[31] ? 32'd0 - data_operandA : data_operandA;
    assign abs_b = data_operandB[31] ? 32'd0 - data_operandB : data_operandB;

    alu #(.W(33)) u_alu (
        .data_operandA  (alu_a),
        .data_operandB  (alu_b),
        .ctrl_ALUopcode (alu_op),
        .data_result    (alu_y)
    );

    // acc is the Booth high half (one guard bit) or the 33-bit remainder
    always_comb begin
        alu_a  = acc;
        alu_b  = 33'd0;
        alu_op = OP_ADD;
        case (state)
            MULT: begin
                if ({q[0], qm1} == 2'b01) begin
                    alu_b = {opb[31], opb};
                end else if ({q[0], qm1} == 2'b10) begin
                    alu_b  = {opb[31], opb};
                    alu_op = OP_SUB;
                end
            end
            DIV: begin
                alu_a  = {acc[31:0], q[31]};
                alu_b  = {1'b0, opb};
                alu_op = acc[32] ? OP_ADD : OP_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 6'd0;
            acc            <= 33'd0;
            q              <= 32'd0;
            qm1            <= 1'b0;
            opb            <= 32'd0;
            is_div         <= 1'b0;
            neg_q          <= 1'b0;
            div0           <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                cnt     <= 6'd0;
                acc     <= 33'd0;
                qm1     <= 1'b0;
                neg_q   <= data_operandA[31] ^ data_operandB[31];
                div0    <= (data_operandB == 32'd0);
                div_ovf <= (data_operandA == 32'h8000_0000) &&
                           (data_operandB == 32'hFFFF_FFFF);
                if (ctrl_MULT) begin
                    state  <= MULT;
                    q      <= data_operandA;
                    opb    <= data_operandB;
                    is_div <= 1'b0;
                end else begin
`ifdef MULTDIV_EARLY_DIV0_EN
                    state  <= (data_operandB == 32'd0) ? DONE : DIV;
`else
                    state  <= DIV;
`endif
                    q      <= abs_a;
                    opb    <= abs_b;
                    is_div <= 1'b1;
                end
            end else begin
                case (state)
                    MULT: begin
                        acc <= {alu_y[32], alu_y[32:1]};
                        q   <= {alu_y[0], q[31:1]};
                        qm1 <= q[0];
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) state <= DONE;
                    end
                    DIV: begin
                        acc <= alu_y;
                        q   <= {q[30:0], ~alu_y[32]};
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) state <= DONE;
                    end
                    DONE: begin
                        state          <= IDLE;
                        data_resultRDY <= 1'b1;
                        if (is_div) begin
                            data_exception <= div0 | div_ovf;
                            if (div0)
                                data_result <= 32'd0;
                            else
                                data_result <= neg_q ? 32'd0 - q : q;
                        end else begin
                            data_result    <= q;
                            data_exception <= ({acc, q[31]} != {34{q[31]}});
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: random and directed multiply/divide
// operations against an arithmetic reference model.

module tb_multdiv;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int   cyc = 0;
    int   cmp = 0;
    int   bad = 0;
    exp_t sb[$];

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        cmp++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input bit m, input logic [31:0] a,
                                   input logic [31:0] b, input int c);
        exp_t   e;
        longint p;
        int     sa;
        int     sbv;
        e.cyc = c + 34;
        if (m) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(e.res)));
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
`ifdef MULTDIV_EARLY_DIV0_EN
            e.cyc = c + 2;
`endif
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            sa    = a;
            sbv   = b;
            e.res = sa / sbv;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic issue(input bit m, input logic [31:0] a,
                         input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = !m;
        sb.push_back(model(m, a, b, cyc));
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clock);
        #1;
        cmp++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL timeout: %0d results outstanding, required 0",
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp[5];
        sp = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0: return sp[$urandom_range(0, 4)];
            1: return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                cmp++;
                bad++;
                $display("FAIL spurious_rdy: got rdy=1 required 0 (cycle %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("result", data_result, e.res);
                chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

        issue(1'b1, 32'd7, 32'hFFFF_FFFA);
        wait_idle();
        chk("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
        issue(1'b1, 32'h0001_0000, 32'h0001_0000);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFD5, 32'd5);
        wait_idle();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(1'b0, 32'd100, 32'd0);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_idle();

        // Abort: DIV started, MULT restarts it ten edges later
        issue(1'b0, 32'd1000, 32'd10);
        idle(9);
        void'(sb.pop_back());
        issue(1'b1, 32'd3, 32'd4);
        wait_idle();

        // Start accepted in the same cycle as the completion pulse
        issue(1'b1, 32'd12345, 32'hFFFF_0001);
        e = sb[0];
        for (int i = 0; i < 60 && cyc < e.cyc; i++) @(posedge clock);
        #1;
        issue(1'b0, 32'd77, 32'hFFFF_FFF9);
        wait_idle();

        // Reset mid-operation, with a simultaneous start that must lose
        issue(1'b1, 32'd5, 32'd6);
        idle(13);
        void'(sb.pop_back());
        reset    = 1'b1;
        ctrl_DIV = 1'b1;
        idle(1);
        reset    = 1'b0;
        ctrl_DIV = 1'b0;
        chk("rst_mid_result", data_result, 32'd0);
        chk("rst_mid_exc", {31'd0, data_exception}, 32'd0);
        chk("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
        idle(50);
        issue(1'b0, 32'd9, 32'd3);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = pick();
            b = pick();
            issue(1'($urandom_range(0, 1)), a, b);
            wait_idle();
            idle($urandom_range(0, 3));
        end

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
